// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: one-hot state codes, coin values, money limit.
package vend_pkg;

  typedef logic [6:0] state_t;

  localparam state_t ST_IDLE   = 7'b0000001;
  localparam state_t ST_SEL1   = 7'b0000010;
  localparam state_t ST_SEL2   = 7'b0000100;
  localparam state_t ST_PAY    = 7'b0001000;
  localparam state_t ST_CHANGE = 7'b0010000;
  localparam state_t ST_REFUND = 7'b0100000;
  localparam state_t ST_DONE   = 7'b1000000;

  localparam int unsigned COIN_1  = 1;
  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;

  localparam logic [7:0] MONEY_MAX = 8'd99;

  // Simultaneous coin pulses add up; the largest possible sum is 16.
  function automatic logic [4:0] coin_value(input logic c1, input logic c5, input logic c10);
    return (c1  ? 5'(COIN_1)  : 5'd0) +
           (c5  ? 5'(COIN_5)  : 5'd0) +
           (c10 ? 5'(COIN_10) : 5'd0);
  endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// Dwell timer for the CHANGE/REFUND/DONE states: free-running count, restarted on every state change.
module vend_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 200_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  output logic expire
);

  logic [31:0] cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) cnt_q <= '0;
    else                  cnt_q <= cnt_q + 32'd1;
  end

  assign expire = (cnt_q == 32'(HOLD_CYCLES - 1));

endmodule

// File: rtl/vend_payment_fsm.sv
// Vending transaction controller: goods selection, coin accumulation, change/refund and dispense.
//  state  | meaning
//  IDLE   | waiting for a button to start selecting
//  SEL1   | choosing quantity of goods 1
//  SEL2   | choosing quantity of goods 2
//  PAY    | accepting coins until the amount due is covered
//  CHANGE | paid; showing change for the hold time
//  REFUND | cancelled; showing refund for the hold time
//  DONE   | display blank for the hold time, then back to IDLE
module vend_payment_fsm
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_ONE   = 12,
  parameter int unsigned PRICE_TWO   = 15,
  parameter int unsigned HOLD_CYCLES = 200_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_cancel,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [6:0] state,
  output logic [7:0] need_money,
  output logic [7:0] input_money,
  output logic [7:0] change_money,
  output logic [3:0] goods_one_high,
  output logic [3:0] goods_one_low,
  output logic [3:0] goods_two_high,
  output logic [3:0] goods_two_low,
  output logic [1:0] goods_one_num,
  output logic [1:0] goods_two_num,
  output logic       coin_reject,
  output logic       vend_pulse
);

  state_t     state_q, state_nxt;
  logic [1:0] n1_q, n1_nxt, n2_q, n2_nxt;
  logic [7:0] need_q, need_nxt, input_q, input_nxt, change_q, change_nxt;
  logic       reject_q, reject_nxt, vend_q, vend_nxt;

  logic       hold_expire, state_chg;
  logic [4:0] coin_sum;
  logic       any_coin, coin_over, pay_done, qty_zero;
  logic [8:0] pay_total;
  logic [7:0] pay_new, need_calc;

  assign coin_sum  = coin_value(coin_1, coin_5, coin_10);
  assign any_coin  = coin_1 | coin_5 | coin_10;
  assign pay_total = {1'b0, input_q} + {4'b0, coin_sum};
  assign coin_over = pay_total > {1'b0, MONEY_MAX};
  assign pay_new   = coin_over ? input_q : pay_total[7:0];
  assign pay_done  = pay_new >= need_q;
  assign qty_zero  = (n1_q == 2'd0) && (n2_q == 2'd0);
  assign need_calc = 8'(n1_q) * 8'(PRICE_ONE) + 8'(n2_q) * 8'(PRICE_TWO);
  assign state_chg = state_nxt != state_q;

  vend_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clear   (state_chg),
    .expire  (hold_expire)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      n1_q     <= '0;
      n2_q     <= '0;
      need_q   <= '0;
      input_q  <= '0;
      change_q <= '0;
      reject_q <= 1'b0;
      vend_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      n1_q     <= n1_nxt;
      n2_q     <= n2_nxt;
      need_q   <= need_nxt;
      input_q  <= input_nxt;
      change_q <= change_nxt;
      reject_q <= reject_nxt;
      vend_q   <= vend_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (btn_inc || btn_next) state_nxt = ST_SEL1;
      ST_SEL1:   if (btn_cancel) state_nxt = ST_IDLE;
                 else if (btn_next) state_nxt = ST_SEL2;
      ST_SEL2:   if (btn_cancel) state_nxt = ST_IDLE;
                 else if (btn_next) state_nxt = qty_zero ? ST_IDLE : ST_PAY;
      // Completing payment outranks a cancel in the same cycle.
      ST_PAY:    if (pay_done) state_nxt = ST_CHANGE;
                 else if (btn_cancel) state_nxt = ST_REFUND;
      ST_CHANGE,
      ST_REFUND: if (hold_expire) state_nxt = ST_DONE;
      ST_DONE:   if (hold_expire) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    n1_nxt     = n1_q;
    n2_nxt     = n2_q;
    need_nxt   = need_q;
    input_nxt  = input_q;
    change_nxt = change_q;
    reject_nxt = any_coin && (state_q != ST_PAY);
    vend_nxt   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_IDLE) ? (btn_inc || btn_next) : hold_expire) begin
          n1_nxt     = '0;
          n2_nxt     = '0;
          need_nxt   = '0;
          input_nxt  = '0;
          change_nxt = '0;
        end
      end
      ST_SEL1: begin
        if (btn_cancel) begin
          n1_nxt = '0;
          n2_nxt = '0;
        end else if (!btn_next && btn_inc) n1_nxt = n1_q + 2'd1;
      end
      ST_SEL2: begin
        if (btn_cancel) begin
          n1_nxt = '0;
          n2_nxt = '0;
        end else if (btn_next) begin
          if (!qty_zero) need_nxt = need_calc;
        end else if (btn_inc) n2_nxt = n2_q + 2'd1;
      end
      ST_PAY: begin
        reject_nxt = coin_over;
        input_nxt  = pay_new;
        if (pay_done)        change_nxt = pay_new - need_q;
        else if (btn_cancel) change_nxt = pay_new;
      end
      ST_CHANGE: vend_nxt = hold_expire;
      default: ;
    endcase
  end

  assign state          = state_q;
  assign need_money     = need_q;
  assign input_money    = input_q;
  assign change_money   = change_q;
  assign goods_one_num  = n1_q;
  assign goods_two_num  = n2_q;
  assign coin_reject    = reject_q;
  assign vend_pulse     = vend_q;
  assign goods_one_high = 4'(PRICE_ONE / 10);
  assign goods_one_low  = 4'(PRICE_ONE % 10);
  assign goods_two_high = 4'(PRICE_TWO / 10);
  assign goods_two_low  = 4'(PRICE_TWO % 10);

endmodule

// File: tb/tb_vend_payment_fsm.sv
// Directed bench for vend_payment_fsm: vector table for the main flows plus dwell/pulse sequences.
module tb_vend_payment_fsm;

  localparam int SI = 1, SS1 = 2, SS2 = 4, SP = 8, SC = 16, SR = 32, SD = 64;
  localparam bit [6:0] NONE = 7'h00, INC = 7'h40, NXT = 7'h20, CAN = 7'h10,
                       C1 = 7'h08, C5 = 7'h04, C10 = 7'h02, RST = 7'h01;

  logic       sys_clk = 1'b0;
  logic       sys_rst, btn_inc, btn_next, btn_cancel, coin_1, coin_5, coin_10;
  logic [6:0] state;
  logic [7:0] need_money, input_money, change_money;
  logic [3:0] goods_one_high, goods_one_low, goods_two_high, goods_two_low;
  logic [1:0] goods_one_num, goods_two_num;
  logic       coin_reject, vend_pulse;

  vend_payment_fsm #(.PRICE_ONE(12), .PRICE_TWO(15), .HOLD_CYCLES(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .btn_inc(btn_inc), .btn_next(btn_next),
    .btn_cancel(btn_cancel), .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
    .state(state), .need_money(need_money), .input_money(input_money),
    .change_money(change_money), .goods_one_high(goods_one_high),
    .goods_one_low(goods_one_low), .goods_two_high(goods_two_high),
    .goods_two_low(goods_two_low), .goods_one_num(goods_one_num),
    .goods_two_num(goods_two_num), .coin_reject(coin_reject), .vend_pulse(vend_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string    name;
    bit [6:0] in;
    int       st, need, inp, chg, n1, n2, rej, vend;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input string nm, input bit [6:0] in, input int st, input int need,
                     input int inp, input int chg, input int n1, input int n2,
                     input int rej, input int vend);
    vec_t v;
    v.name = nm; v.in = in; v.st = st; v.need = need; v.inp = inp; v.chg = chg;
    v.n1 = n1; v.n2 = n2; v.rej = rej; v.vend = vend;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic cyc(input bit [6:0] in);
    {btn_inc, btn_next, btn_cancel, coin_1, coin_5, coin_10, sys_rst} = in;
    @(posedge sys_clk);
    #1;
  endtask

  // Payment for one goods-2 (need 15) ending in CHANGE or REFUND; measures dwell and dispense pulses.
  task automatic hold_seq(input bit refund);
    string tag;
    int    dwell, vends, hold_st;
    tag     = refund ? "refund" : "cancel_complete";
    hold_st = refund ? SR : SC;
    cyc(NXT); cyc(NXT); cyc(INC); cyc(NXT);
    chk({tag, ".need"}, int'(need_money), 15);
    cyc(C5);
    chk({tag, ".input5"}, int'(input_money), 5);
    if (refund) cyc(CAN);
    else        cyc(C10 | CAN);
    chk({tag, ".state"}, int'(state), hold_st);
    chk({tag, ".change"}, int'(change_money), refund ? 5 : 0);
    dwell = 1;
    vends = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(NONE);
      vends += int'(vend_pulse);
      if (int'(state) != hold_st) break;
      dwell++;
    end
    chk({tag, ".hold_dwell"}, dwell, 4);
    chk({tag, ".to_done"}, int'(state), SD);
    dwell = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(NONE);
      vends += int'(vend_pulse);
      if (int'(state) != SD) break;
      dwell++;
    end
    chk({tag, ".done_dwell"}, dwell, 4);
    chk({tag, ".to_idle"}, int'(state), SI);
    chk({tag, ".vend_count"}, vends, refund ? 0 : 1);
    chk({tag, ".input_cleared"}, int'(input_money), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {btn_inc, btn_next, btn_cancel, coin_1, coin_5, coin_10} = '0;
    sys_rst = 1'b1;

    // reset, coin outside PAY, quantity wrap, zero-quantity exit
    add("rst0",       RST,  SI, 0, 0, 0, 0, 0, 0, 0);
    add("rst1",       RST,  SI, 0, 0, 0, 0, 0, 0, 0);
    add("coin_idle",  C10,  SI, 0, 0, 0, 0, 0, 1, 0);
    add("idle_quiet", NONE, SI, 0, 0, 0, 0, 0, 0, 0);
    add("w_sel1",     NXT,  SS1, 0, 0, 0, 0, 0, 0, 0);
    add("w_inc1",     INC,  SS1, 0, 0, 0, 1, 0, 0, 0);
    add("w_inc2",     INC,  SS1, 0, 0, 0, 2, 0, 0, 0);
    add("w_inc3",     INC,  SS1, 0, 0, 0, 3, 0, 0, 0);
    add("w_inc4",     INC,  SS1, 0, 0, 0, 0, 0, 0, 0);
    add("w_sel2",     NXT,  SS2, 0, 0, 0, 0, 0, 0, 0);
    add("w_zero",     NXT,  SI, 0, 0, 0, 0, 0, 0, 0);
    // exact payment 10+1+1 for need 12, coin rejected during CHANGE
    add("x_sel1",     NXT,  SS1, 0, 0, 0, 0, 0, 0, 0);
    add("x_inc",      INC,  SS1, 0, 0, 0, 1, 0, 0, 0);
    add("x_sel2",     NXT,  SS2, 0, 0, 0, 1, 0, 0, 0);
    add("x_pay",      NXT,  SP, 12, 0, 0, 1, 0, 0, 0);
    add("x_c10",      C10,  SP, 12, 10, 0, 1, 0, 0, 0);
    add("x_c1a",      C1,   SP, 12, 11, 0, 1, 0, 0, 0);
    add("x_c1b",      C1,   SC, 12, 12, 0, 1, 0, 0, 0);
    add("x_hold1",    NONE, SC, 12, 12, 0, 1, 0, 0, 0);
    add("x_coin_chg", C1,   SC, 12, 12, 0, 1, 0, 1, 0);
    add("x_hold3",    NONE, SC, 12, 12, 0, 1, 0, 0, 0);
    add("x_done",     NONE, SD, 12, 12, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add("x_dhold", NONE, SD, 12, 12, 0, 1, 0, 0, 0);
    add("x_idle",     NONE, SI, 0, 0, 0, 0, 0, 0, 0);
    // overpay: need 39, four coin_10
    add("o_sel1",     NXT,  SS1, 0, 0, 0, 0, 0, 0, 0);
    add("o_inc1",     INC,  SS1, 0, 0, 0, 1, 0, 0, 0);
    add("o_inc2",     INC,  SS1, 0, 0, 0, 2, 0, 0, 0);
    add("o_sel2",     NXT,  SS2, 0, 0, 0, 2, 0, 0, 0);
    add("o_inc",      INC,  SS2, 0, 0, 0, 2, 1, 0, 0);
    add("o_pay",      NXT,  SP, 39, 0, 0, 2, 1, 0, 0);
    for (int i = 1; i <= 3; i++) add("o_c10", C10, SP, 39, 10 * i, 0, 2, 1, 0, 0);
    add("o_c10_last", C10,  SC, 39, 40, 1, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) add("o_hold", NONE, SC, 39, 40, 1, 2, 1, 0, 0);
    add("o_done",     NONE, SD, 39, 40, 1, 2, 1, 0, 1);
    for (int i = 0; i < 3; i++) add("o_dhold", NONE, SD, 39, 40, 1, 2, 1, 0, 0);
    add("o_idle",     NONE, SI, 0, 0, 0, 0, 0, 0, 0);
    // need 81, seven coin_10 then a 1+5+10 cycle
    add("s_sel1",     NXT,  SS1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add("s_inc1", INC, SS1, 0, 0, 0, i, 0, 0, 0);
    add("s_sel2",     NXT,  SS2, 0, 0, 0, 3, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add("s_inc2", INC, SS2, 0, 0, 0, 3, i, 0, 0);
    add("s_pay",      NXT,  SP, 81, 0, 0, 3, 3, 0, 0);
    for (int i = 1; i <= 7; i++) add("s_c10", C10, SP, 81, 10 * i, 0, 3, 3, 0, 0);
    add("s_multi",    C1 | C5 | C10, SC, 81, 86, 5, 3, 3, 0, 0);
    add("s_c10_chg",  C10,  SC, 81, 86, 5, 3, 3, 1, 0);
    for (int i = 0; i < 2; i++) add("s_hold", NONE, SC, 81, 86, 5, 3, 3, 0, 0);
    add("s_done",     NONE, SD, 81, 86, 5, 3, 3, 0, 1);
    for (int i = 0; i < 3; i++) add("s_dhold", NONE, SD, 81, 86, 5, 3, 3, 0, 0);
    add("s_idle",     NONE, SI, 0, 0, 0, 0, 0, 0, 0);
    // reset in PAY with 17 inserted
    add("r_sel1",     NXT,  SS1, 0, 0, 0, 0, 0, 0, 0);
    add("r_inc1",     INC,  SS1, 0, 0, 0, 1, 0, 0, 0);
    add("r_sel2",     NXT,  SS2, 0, 0, 0, 1, 0, 0, 0);
    add("r_inc2",     INC,  SS2, 0, 0, 0, 1, 1, 0, 0);
    add("r_pay",      NXT,  SP, 27, 0, 0, 1, 1, 0, 0);
    add("r_c10",      C10,  SP, 27, 10, 0, 1, 1, 0, 0);
    add("r_c5",       C5,   SP, 27, 15, 0, 1, 1, 0, 0);
    add("r_c1a",      C1,   SP, 27, 16, 0, 1, 1, 0, 0);
    add("r_c1b",      C1,   SP, 27, 17, 0, 1, 1, 0, 0);
    add("r_reset",    RST | C1, SI, 0, 0, 0, 0, 0, 0, 0);
    add("r_after",    NONE, SI, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].in);
      chk($sformatf("v%0d %s state",  i, vecs[i].name), int'(state),         vecs[i].st);
      chk($sformatf("v%0d %s need",   i, vecs[i].name), int'(need_money),    vecs[i].need);
      chk($sformatf("v%0d %s input",  i, vecs[i].name), int'(input_money),   vecs[i].inp);
      chk($sformatf("v%0d %s change", i, vecs[i].name), int'(change_money),  vecs[i].chg);
      chk($sformatf("v%0d %s num1",   i, vecs[i].name), int'(goods_one_num), vecs[i].n1);
      chk($sformatf("v%0d %s num2",   i, vecs[i].name), int'(goods_two_num), vecs[i].n2);
      chk($sformatf("v%0d %s reject", i, vecs[i].name), int'(coin_reject),   vecs[i].rej);
      chk($sformatf("v%0d %s vend",   i, vecs[i].name), int'(vend_pulse),    vecs[i].vend);
    end

    chk("price1_high", int'(goods_one_high), 1);
    chk("price1_low",  int'(goods_one_low),  2);
    chk("price2_high", int'(goods_two_high), 1);
    chk("price2_low",  int'(goods_two_low),  5);

    hold_seq(1'b0);
    hold_seq(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
